// File: rtl/bitserial_encoder_mc.sv
// bitserial_encoder_mc: LANES parallel RSC encoders (g0=1+D^2+D^3, g1=1+D+D^3) sharing one beat handshake.
// Latency: one cycle. A beat accepted at edge N is presented with out_valid from after edge N.
// Backpressure: one output register. Input and encoder state are frozen while out_valid && !out_ready; a tail stalls with it.
module bitserial_encoder_mc #(
  parameter int LANES       = 1,
  parameter int TERM_CYCLES = 3,
  parameter int CNT_W       = 16
) (
  input  logic             clock,
  input  logic             aclr_n,
  input  logic [LANES-1:0] bits_in,
  input  logic             bits_in_valid,
  input  logic             in_last_bits,
  input  logic             term_en,
  output logic             bits_in_ready,
  output logic [LANES-1:0] x_bits_out,
  output logic [LANES-1:0] z_bits_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             tail,
  output logic             out_last,
  output logic [CNT_W-1:0] frame_bits
);

  localparam int TC_W = (TERM_CYCLES > 1) ? $clog2(TERM_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    TAIL = 2'd2
  } state_t;

  // Frame control
  state_t           state_q, state_d;
  logic             term_q, term_d;
  logic [TC_W-1:0]  tcnt_q, tcnt_d;

  // Per-lane shift registers. Lane i lives in bit i of each vector.
  // s1 is the newest stage.
  logic [LANES-1:0] s1_q, s1_d;
  logic [LANES-1:0] s2_q, s2_d;
  logic [LANES-1:0] s3_q, s3_d;

  // Output register
  logic             out_valid_q, out_valid_d;
  logic [LANES-1:0] x_q, x_d;
  logic [LANES-1:0] z_q, z_d;
  logic             tail_q, tail_d;
  logic             last_q, last_d;

  // Frame length bookkeeping
  logic [CNT_W-1:0] fcnt_q, fcnt_d;
  logic [CNT_W-1:0] fbits_q, fbits_d;

  // Shared handshake terms
  logic             slot_free;
  logic             in_ready;
  logic             in_acc;
  logic             tail_ld;
  logic             last_tail;
  logic             term_eff;
  logic             last_plain;
  logic [CNT_W-1:0] fcnt_inc;

  // Encoder datapath
  logic [LANES-1:0] c_bits;
  logic [LANES-1:0] a_bits;
  logic [LANES-1:0] z_bits;

  // The output slot is free when empty or being drained on this edge.
  assign slot_free  = !out_valid_q || out_ready;
  assign in_ready   = (state_q != TAIL) && slot_free;
  assign in_acc     = bits_in_valid && in_ready;
  assign tail_ld    = (state_q == TAIL) && slot_free;
  assign last_tail  = tail_ld && (tcnt_q == '0);

  // term_en is only meaningful on the first beat of a frame.
  // In IDLE the live pin is used; later beats use the latched copy.
  assign term_eff   = (state_q == IDLE) ? term_en : term_q;

  // Last data beat of an unterminated frame: closes the frame and clears lane state.
  assign last_plain = in_acc && in_last_bits && !term_eff;

  assign fcnt_inc   = (fcnt_q == {CNT_W{1'b1}}) ? fcnt_q : fcnt_q + CNT_W'(1);

  // In a tail beat the input is chosen so the feedback term a is zero.
  // Three such beats flush the register. Any extra tail beats then give x = z = 0.
  assign c_bits = (state_q == TAIL) ? (s2_q ^ s3_q) : bits_in;
  assign a_bits = c_bits ^ s2_q ^ s3_q;
  assign z_bits = a_bits ^ s1_q ^ s3_q;

  // Frame FSM: IDLE/DATA accept data beats; TAIL counts tail beats down to zero.
  always_comb begin
    state_d = state_q;
    term_d  = term_q;
    tcnt_d  = tcnt_q;
    case (state_q)
      IDLE, DATA: begin
        if (in_acc) begin
          if (state_q == IDLE) begin
            term_d = term_en;
          end
          if (in_last_bits) begin
            if (term_eff) begin
              state_d = TAIL;
              tcnt_d  = TC_W'(TERM_CYCLES - 1);
            end else begin
              state_d = IDLE;
            end
          end else begin
            state_d = DATA;
          end
        end
      end
      TAIL: begin
        if (tail_ld) begin
          if (tcnt_q == '0) begin
            state_d = IDLE;
          end else begin
            tcnt_d = tcnt_q - TC_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Encoder state, output register and frame counter. All advance only when a beat loads.
  always_comb begin
    s1_d        = s1_q;
    s2_d        = s2_q;
    s3_d        = s3_q;
    out_valid_d = out_valid_q;
    x_d         = x_q;
    z_d         = z_q;
    tail_d      = tail_q;
    last_d      = last_q;
    fcnt_d      = fcnt_q;
    fbits_d     = fbits_q;

    if (in_acc || tail_ld) begin
      out_valid_d = 1'b1;
      x_d         = c_bits;
      z_d         = z_bits;
      tail_d      = tail_ld;
      last_d      = tail_ld ? last_tail : (in_last_bits && !term_eff);
      if (last_plain || last_tail) begin
        s1_d = '0;
        s2_d = '0;
        s3_d = '0;
      end else begin
        s1_d = a_bits;
        s2_d = s1_q;
        s3_d = s2_q;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    if (in_acc) begin
      if (in_last_bits) begin
        fbits_d = fcnt_inc;
        fcnt_d  = '0;
      end else begin
        fcnt_d  = fcnt_inc;
      end
    end
  end

  // State registers with synchronous active-low clear.
  // A clear mid-frame drops the frame with no out_last.
  always_ff @(posedge clock) begin
    if (!aclr_n) begin
      state_q     <= IDLE;
      term_q      <= 1'b0;
      tcnt_q      <= '0;
      s1_q        <= '0;
      s2_q        <= '0;
      s3_q        <= '0;
      out_valid_q <= 1'b0;
      x_q         <= '0;
      z_q         <= '0;
      tail_q      <= 1'b0;
      last_q      <= 1'b0;
      fcnt_q      <= '0;
      fbits_q     <= '0;
    end else begin
      state_q     <= state_d;
      term_q      <= term_d;
      tcnt_q      <= tcnt_d;
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      s3_q        <= s3_d;
      out_valid_q <= out_valid_d;
      x_q         <= x_d;
      z_q         <= z_d;
      tail_q      <= tail_d;
      last_q      <= last_d;
      fcnt_q      <= fcnt_d;
      fbits_q     <= fbits_d;
    end
  end

  assign bits_in_ready = in_ready;
  assign x_bits_out    = x_q;
  assign z_bits_out    = z_q;
  assign out_valid     = out_valid_q;
  assign tail          = tail_q;
  assign out_last      = last_q;
  assign frame_bits    = fbits_q;

endmodule

// File: tb/tb_bitserial_encoder_mc.sv
// Bench for bitserial_encoder_mc. It uses two instances:
//   A: LANES=1, TERM_CYCLES=3, CNT_W=4
//   B: LANES=4, TERM_CYCLES=5, CNT_W=16
// Expected beats are queued when a frame is driven and popped as the DUT hands beats out.
`timescale 1ns/1ps
module tb_bitserial_encoder_mc;

  typedef struct packed {
    logic       tl;
    logic       lst;
    logic [3:0] x;
    logic [3:0] z;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // Instance A
  logic       a_bits, a_vld, a_last, a_term, a_rdy, a_x, a_z, a_ov, a_ordy, a_tail, a_olast;
  logic [3:0] a_fb;

  // Instance B
  logic [3:0]  b_bits, b_x, b_z;
  logic        b_vld, b_last, b_term, b_rdy, b_ov, b_ordy, b_tail, b_olast;
  logic [15:0] b_fb;

  bitserial_encoder_mc #(.LANES(1), .TERM_CYCLES(3), .CNT_W(4)) u_a (
    .clock(clk), .aclr_n(rst_n), .bits_in(a_bits), .bits_in_valid(a_vld),
    .in_last_bits(a_last), .term_en(a_term), .bits_in_ready(a_rdy),
    .x_bits_out(a_x), .z_bits_out(a_z), .out_valid(a_ov), .out_ready(a_ordy),
    .tail(a_tail), .out_last(a_olast), .frame_bits(a_fb)
  );

  bitserial_encoder_mc #(.LANES(4), .TERM_CYCLES(5), .CNT_W(16)) u_b (
    .clock(clk), .aclr_n(rst_n), .bits_in(b_bits), .bits_in_valid(b_vld),
    .in_last_bits(b_last), .term_en(b_term), .bits_in_ready(b_rdy),
    .x_bits_out(b_x), .z_bits_out(b_z), .out_valid(b_ov), .out_ready(b_ordy),
    .tail(b_tail), .out_last(b_olast), .frame_bits(b_fb)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  beat_t      qa[$];
  beat_t      qb[$];
  logic [3:0] fr_dat[64];
  logic [3:0] ms1[2], ms2[2], ms3[2];
  bit         rand_rdy[2];
  beat_t      prev[2];
  bit         stall[2];

  // Scalar reference model, applied to four lanes at once.
  // The result is pushed to the queue of instance k.
  task automatic model_push(input int k, input int n, input bit term, input int tc);
    beat_t      e;
    logic [3:0] c, a;
    for (int b = 0; b < n; b++) begin
      c     = (k == 0) ? {3'b000, fr_dat[b][0]} : fr_dat[b];
      a     = c ^ ms2[k] ^ ms3[k];
      e.tl  = 1'b0;
      e.lst = (b == n - 1) && !term;
      e.x   = c;
      e.z   = a ^ ms1[k] ^ ms3[k];
      ms3[k] = ms2[k];
      ms2[k] = ms1[k];
      ms1[k] = a;
      if (k == 0) qa.push_back(e); else qb.push_back(e);
    end
    if (!term) begin
      ms1[k] = '0;
      ms2[k] = '0;
      ms3[k] = '0;
    end else begin
      for (int t = 0; t < tc; t++) begin
        c     = ms2[k] ^ ms3[k];
        e.tl  = 1'b1;
        e.lst = (t == tc - 1);
        e.x   = c;
        e.z   = ms1[k] ^ ms3[k];
        ms3[k] = ms2[k];
        ms2[k] = ms1[k];
        ms1[k] = 4'b0000;
        if (k == 0) qa.push_back(e); else qb.push_back(e);
      end
    end
  endtask

  task automatic push_lit(input logic tl, input logic lst, input logic [3:0] x, input logic [3:0] z);
    beat_t e;
    e.tl  = tl;
    e.lst = lst;
    e.x   = x;
    e.z   = z;
    qa.push_back(e);
  endtask

  // Hand-derived stream for frame 1,0,0 on instance A, starting from state 0.
  task automatic push_ref_100(input bit term);
    push_lit(1'b0, !term, 4'd1, 4'd1);
    push_lit(1'b0, 1'b0,  4'd0, 4'd1);
    push_lit(1'b0, !term, 4'd0, 4'd1);
    if (term) begin
      push_lit(1'b1, 1'b0, 4'd1, 4'd0);
      push_lit(1'b1, 1'b0, 4'd1, 4'd0);
      push_lit(1'b1, 1'b1, 4'd1, 4'd1);
    end
    // The step above makes the first and third beats carry out_last for term=0.
    // Only the third may, so clear the flag on the first.
    if (!term) begin
      beat_t e;
      e = qa[qa.size() - 3];
      e.lst = 1'b0;
      qa[qa.size() - 3] = e;
    end
  endtask

  task automatic set_frame_100();
    fr_dat[0] = 4'd1;
    fr_dat[1] = 4'd0;
    fr_dat[2] = 4'd0;
  endtask

  // Drive n beats from fr_dat into instance k.
  // Each beat waits for bits_in_ready, with a bound.
  task automatic drive_frame(input int k, input int n, input bit term);
    int guard;
    for (int b = 0; b < n; b++) begin
      @(negedge clk); #1;
      if (k == 0) begin
        a_vld  = 1'b1;
        a_bits = fr_dat[b][0];
        a_last = (b == n - 1);
        a_term = term;
      end else begin
        b_vld  = 1'b1;
        b_bits = fr_dat[b];
        b_last = (b == n - 1);
        b_term = term;
      end
      guard = 0;
      #1;
      while (!((k == 0) ? a_rdy : b_rdy)) begin
        guard++;
        if (guard > 300) begin
          tests_run++;
          tests_failed++;
          $display("FAIL accept_timeout k%0d beat %0d: ready stayed 0, required 1", k, b);
          a_vld = 1'b0;
          b_vld = 1'b0;
          return;
        end
        @(negedge clk); #2;
      end
      @(posedge clk);
    end
    @(negedge clk); #1;
    a_vld  = 1'b0;
    a_last = 1'b0;
    b_vld  = 1'b0;
    b_last = 1'b0;
  endtask

  task automatic drain(input int k);
    int g;
    g = 0;
    while (((k == 0) ? qa.size() : qb.size()) > 0 && g < 1000) begin
      @(negedge clk);
      g++;
    end
    @(negedge clk);
    tests_run++;
    if (((k == 0) ? qa.size() : qb.size()) != 0) begin
      tests_failed++;
      $display("FAIL drain_k%0d: %0d beats still pending, required 0", k,
               (k == 0) ? qa.size() : qb.size());
      if (k == 0) qa.delete(); else qb.delete();
    end
  endtask

  // out_ready: held high, or random per cycle when enabled.
  initial begin
    a_ordy = 1'b1;
    b_ordy = 1'b1;
    forever begin
      @(negedge clk); #1;
      a_ordy = rand_rdy[0] ? 1'($urandom_range(0, 1)) : 1'b1;
      b_ordy = rand_rdy[1] ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Scoreboard monitor. Sampled mid-low-phase, when inputs are settled.
  // Also checks that a stalled beat holds steady.
  always @(negedge clk) begin
    #3;
    for (int k = 0; k < 2; k++) begin
      beat_t cur, exp_b;
      logic  ov, ordy;
      bit    has_exp;
      ov   = (k == 0) ? a_ov : b_ov;
      ordy = (k == 0) ? a_ordy : b_ordy;
      cur  = (k == 0) ? {a_tail, a_olast, 3'b000, a_x, 3'b000, a_z}
                      : {b_tail, b_olast, b_x, b_z};
      if (!rst_n) begin
        stall[k] = 1'b0;
      end else begin
        if (stall[k]) begin
          tests_run++;
          if (!ov || cur !== prev[k]) begin
            tests_failed++;
            $display("FAIL stall_hold_k%0d: got valid=%b beat=%h, required valid=1 beat=%h", k, ov, cur, prev[k]);
          end
        end
        if (ov && ordy) begin
          tests_run++;
          has_exp = (k == 0) ? (qa.size() > 0) : (qb.size() > 0);
          if (!has_exp) begin
            tests_failed++;
            $display("FAIL unexpected_beat_k%0d: got %h, required no beat", k, cur);
          end else begin
            exp_b = (k == 0) ? qa.pop_front() : qb.pop_front();
            if (cur !== exp_b) begin
              tests_failed++;
              $display("FAIL beat_k%0d {tail,last,x,z}: got %h, required %h", k, cur, exp_b);
            end
          end
        end
        stall[k] = ov && !ordy;
        prev[k]  = cur;
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    a_vld = 1'b0; a_last = 1'b0; a_term = 1'b0; a_bits = 1'b0;
    b_vld = 1'b0; b_last = 1'b0; b_term = 1'b0; b_bits = 4'd0;
    for (int k = 0; k < 2; k++) begin
      ms1[k] = '0;
      ms2[k] = '0;
      ms3[k] = '0;
      rand_rdy[k] = 1'b0;
      stall[k] = 1'b0;
    end
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    #1;
    tests_run++;
    if ({a_ov, a_tail, a_olast, a_x, a_z} !== 5'b0) begin
      tests_failed++;
      $display("FAIL reset_a_outputs: got %b, required 00000", {a_ov, a_tail, a_olast, a_x, a_z});
    end
    tests_run++;
    if (a_fb !== 4'd0 || a_rdy !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_a_fb_rdy: got fb=%0d rdy=%b, required fb=0 rdy=1", a_fb, a_rdy);
    end
    tests_run++;
    if ({b_ov, b_tail, b_olast, b_x, b_z} !== 11'b0 || b_fb !== 16'd0 || b_rdy !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_b: got out=%b fb=%0d rdy=%b, required 0/0/1",
               {b_ov, b_tail, b_olast, b_x, b_z}, b_fb, b_rdy);
    end
  endtask

  task automatic test_tail_basic();
    logic [3:0] seen;
    set_frame_100();
    push_ref_100(1'b1);
    drive_frame(0, 3, 1'b1);
    #1;
    tests_run++;
    if (a_fb !== 4'd3) begin
      tests_failed++;
      $display("FAIL tail_basic_frame_bits: got %0d, required 3", a_fb);
    end
    // Input ready should stay low for exactly TERM_CYCLES cycles.
    seen[0] = a_rdy;
    for (int i = 1; i < 4; i++) begin
      @(negedge clk); #2;
      seen[i] = a_rdy;
    end
    tests_run++;
    if (seen !== 4'b1000) begin
      tests_failed++;
      $display("FAIL tail_ready_gap: got %b, required 1000", seen);
    end
    drain(0);
  endtask

  task automatic test_no_term();
    set_frame_100();
    push_ref_100(1'b0);
    drive_frame(0, 3, 1'b0);
    #1;
    tests_run++;
    if (a_rdy !== 1'b1 || a_fb !== 4'd3) begin
      tests_failed++;
      $display("FAIL no_term_ready_fb: got rdy=%b fb=%0d, required rdy=1 fb=3", a_rdy, a_fb);
    end
    fr_dat[0] = 4'd1; fr_dat[1] = 4'd1; fr_dat[2] = 4'd0; fr_dat[3] = 4'd1;
    model_push(0, 4, 1'b0, 3);
    drive_frame(0, 4, 1'b0);
    #1;
    tests_run++;
    if (a_fb !== 4'd4) begin
      tests_failed++;
      $display("FAIL no_term_second_fb: got %0d, required 4", a_fb);
    end
    drain(0);
  endtask

  task automatic test_multilane();
    fr_dat[0] = 4'h1; fr_dat[1] = 4'h3; fr_dat[2] = 4'h6; fr_dat[3] = 4'hC;
    fr_dat[4] = 4'h9; fr_dat[5] = 4'hF; fr_dat[6] = 4'h0; fr_dat[7] = 4'hA;
    model_push(1, 8, 1'b1, 5);
    drive_frame(1, 8, 1'b1);
    #1;
    tests_run++;
    if (b_fb !== 16'd8) begin
      tests_failed++;
      $display("FAIL multilane_frame_bits: got %0d, required 8", b_fb);
    end
    drain(1);
    for (int b = 0; b < 6; b++) fr_dat[b] = 4'($urandom_range(0, 15));
    model_push(1, 6, 1'b0, 5);
    drive_frame(1, 6, 1'b0);
    drain(1);
  endtask

  task automatic test_backpressure();
    rand_rdy[0] = 1'b1;
    rand_rdy[1] = 1'b1;
    set_frame_100();
    push_ref_100(1'b1);
    drive_frame(0, 3, 1'b1);
    drain(0);
    for (int b = 0; b < 10; b++) fr_dat[b] = 4'($urandom_range(0, 1));
    model_push(0, 10, 1'b1, 3);
    drive_frame(0, 10, 1'b1);
    drain(0);
    for (int b = 0; b < 9; b++) fr_dat[b] = 4'($urandom_range(0, 15));
    model_push(1, 9, 1'b1, 5);
    drive_frame(1, 9, 1'b1);
    drain(1);
    rand_rdy[0] = 1'b0;
    rand_rdy[1] = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_saturation();
    for (int b = 0; b < 20; b++) fr_dat[b] = 4'($urandom_range(0, 1));
    model_push(0, 20, 1'b1, 3);
    drive_frame(0, 20, 1'b1);
    #1;
    tests_run++;
    if (a_fb !== 4'd15) begin
      tests_failed++;
      $display("FAIL saturate_frame_bits: got %0d, required 15", a_fb);
    end
    drain(0);
    for (int f = 0; f < 4; f++) begin
      fr_dat[0] = 4'(f & 1);
      model_push(0, 1, (f == 3), 3);
      drive_frame(0, 1, (f == 3));
      #1;
      tests_run++;
      if (a_fb !== 4'd1) begin
        tests_failed++;
        $display("FAIL single_beat_fb_%0d: got %0d, required 1", f, a_fb);
      end
    end
    drain(0);
  endtask

  task automatic test_reset_mid_tail();
    set_frame_100();
    push_ref_100(1'b1);
    drive_frame(0, 3, 1'b1);
    // Last data beat accepted at edge N. Two more edges put tail beat 2 in the output register.
    @(negedge clk);
    @(negedge clk);
    #1;
    tests_run++;
    if (a_ov !== 1'b1 || a_tail !== 1'b1) begin
      tests_failed++;
      $display("FAIL second_tail_present: got valid=%b tail=%b, required 1/1", a_ov, a_tail);
    end
    rst_n = 1'b0;
    @(negedge clk); #1;
    rst_n = 1'b1;
    #1;
    tests_run++;
    if (a_ov !== 1'b0 || a_tail !== 1'b0 || a_rdy !== 1'b1 || a_olast !== 1'b0) begin
      tests_failed++;
      $display("FAIL after_mid_tail_reset: got valid=%b tail=%b rdy=%b last=%b, required 0/0/1/0",
               a_ov, a_tail, a_rdy, a_olast);
    end
    tests_run++;
    if (qa.size() != 2) begin
      tests_failed++;
      $display("FAIL mid_tail_consumed: got %0d pending, required 2", qa.size());
    end
    qa.delete();
    set_frame_100();
    push_ref_100(1'b1);
    drive_frame(0, 3, 1'b1);
    drain(0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_tail_basic();
    test_no_term();
    test_multilane();
    test_backpressure();
    test_saturation();
    test_reset_mid_tail();
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
